// File: rtl/kgp_risc_defs.sv
// Shared KGP RISC definitions: opcode map, instruction field positions,
// fetch FSM encoding and the decoded-field payload.
package kgp_risc_defs;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPC_W    = 3;
  localparam int unsigned FUNC_W   = 4;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned RSVD_W   = 3;

  localparam int unsigned OPC_LSB  = 29;
  localparam int unsigned RS_LSB   = 24;
  localparam int unsigned RT_LSB   = 19;
  localparam int unsigned RSVD_LSB = 16;
  localparam int unsigned IMM_LSB  = 0;
  localparam int unsigned FUNC_LSB = 0;

  localparam logic [OPC_W-1:0] OPC_ALU_R  = 3'b000;
  localparam logic [OPC_W-1:0] OPC_ALU_I  = 3'b001;
  localparam logic [OPC_W-1:0] OPC_MEM_LD = 3'b010;
  localparam logic [OPC_W-1:0] OPC_MEM_ST = 3'b011;
  localparam logic [OPC_W-1:0] OPC_BR0    = 3'b100;
  localparam logic [OPC_W-1:0] OPC_BR1    = 3'b101;
  localparam logic [OPC_W-1:0] OPC_RSVD   = 3'b110;
  localparam logic [OPC_W-1:0] OPC_SYS    = 3'b111;

  localparam logic [FUNC_W-1:0] FUNC_HALT = 4'b1111;

  typedef enum logic [1:0] {
    S_REQ   = 2'b00,
    S_RESP  = 2'b01,
    S_ISSUE = 2'b10,
    S_HALT  = 2'b11
  } fetch_state_e;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [IMM_W-1:0]  imm16;
    logic [FUNC_W-1:0] funccode;
  } instr_fields_t;

  function automatic logic is_halt(input logic [OPC_W-1:0] opc, input logic [FUNC_W-1:0] func);
    return (opc == OPC_SYS) && (func == FUNC_HALT);
  endfunction

  // SYS is only defined for the HALT function code; opcode 110 is unassigned.
  function automatic logic is_illegal(input logic [OPC_W-1:0] opc, input logic [FUNC_W-1:0] func);
    return (opc == OPC_RSVD) || ((opc == OPC_SYS) && (func != FUNC_HALT));
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Splits a raw instruction word into its opcode/function/register/immediate fields.
module instr_field_split
  import kgp_risc_defs::*;
(
  input  logic [INSTR_W-1:0] ir,
  output instr_fields_t      fields
);

  logic rsvd_unused;

  assign fields.opcode   = ir[OPC_LSB  +: OPC_W];
  assign fields.rs       = ir[RS_LSB   +: REG_W];
  assign fields.rt       = ir[RT_LSB   +: REG_W];
  assign fields.imm16    = ir[IMM_LSB  +: IMM_W];
  assign fields.funccode = ir[FUNC_LSB +: FUNC_W];

  // Bits between rt and imm16 carry no field in this ISA.
  assign rsvd_unused = ^ir[RSVD_LSB +: RSVD_W];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, BRAM request/response, valid/ready issue to Control_Unit,
// branch redirect and HALT handling.
module instr_fetch_unit
  import kgp_risc_defs::*;
#(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned          IMEM_AW  = 10
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_en,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                instr_ready,
  output logic                instr_valid,
  output logic [OPC_W-1:0]    opcode,
  output logic [FUNC_W-1:0]   Funccode,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [IMM_W-1:0]    imm16,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                halted,
  output logic                illegal_instr
);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
  logic                valid_q, valid_d;
  logic                imem_en_q, imem_en_d;
  logic [IMEM_AW-1:0]  imem_addr_q, imem_addr_d;
  logic                halted_q, halted_d;
  logic                illegal_q, illegal_d;

  instr_fields_t       fields;
  logic                redirect;
  logic                xfer;
  logic [PC_WIDTH-1:0] target_aligned;
  logic                target_lsb_unused;

  instr_field_split u_split (
    .ir     (ir_q),
    .fields (fields)
  );

  assign target_aligned    = {branch_target[PC_WIDTH-1:2], 2'b00};
  assign target_lsb_unused = ^branch_target[1:0];
  assign redirect          = branch_taken && (state_q != S_HALT);
  assign xfer              = valid_q && instr_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    pc_out_d    = pc_out_q;
    valid_d     = 1'b0;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
    imem_en_d   = 1'b0;
    imem_addr_d = imem_addr_q;

    unique case (state_q)
      // The first REQ after reset only arms imem_en; the read is issued next cycle.
      S_REQ: begin
        if (imem_en_q) state_d = S_RESP;
      end
      S_RESP: begin
        ir_d     = imem_rdata;
        pc_out_d = pc_q;
        pc_d     = pc_q + PC_WIDTH'(4);
        valid_d  = 1'b1;
        state_d  = S_ISSUE;
        if (is_illegal(imem_rdata[OPC_LSB +: OPC_W], imem_rdata[FUNC_LSB +: FUNC_W]))
          illegal_d = 1'b1;
      end
      S_ISSUE: begin
        valid_d = 1'b1;
        if (xfer) begin
          valid_d = 1'b0;
          if (is_halt(fields.opcode, fields.funccode)) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_REQ;
    endcase

    // Redirect discards whatever is in flight or held in IR.
    if (redirect) begin
      pc_d      = target_aligned;
      state_d   = S_REQ;
      valid_d   = 1'b0;
      ir_d      = ir_q;
      pc_out_d  = pc_out_q;
      halted_d  = halted_q;
      illegal_d = illegal_q;
    end

    imem_en_d = (state_d == S_REQ);
    if (imem_en_d) imem_addr_d = pc_d[IMEM_AW+1:2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      pc_out_q    <= '0;
      valid_q     <= 1'b0;
      imem_en_q   <= 1'b0;
      imem_addr_q <= '0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
      imem_en_q   <= imem_en_d;
      imem_addr_q <= imem_addr_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
    end
  end

  assign imem_en       = imem_en_q;
  assign imem_addr     = imem_addr_q;
  assign instr_valid   = valid_q;
  assign opcode        = fields.opcode;
  assign Funccode      = fields.funccode;
  assign rs            = fields.rs;
  assign rt            = fields.rt;
  assign imm16         = fields.imm16;
  assign pc_out        = pc_out_q;
  assign halted        = halted_q;
  assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run checked
// against a program-order model with a behavioural BRAM.
module tb_instr_fetch_unit;

  localparam int unsigned PC_WIDTH = 32;
  localparam int unsigned IMEM_AW  = 10;
  localparam int unsigned DEPTH    = 1 << IMEM_AW;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                imem_en;
  logic [IMEM_AW-1:0]  imem_addr;
  logic [31:0]         imem_rdata = '0;
  logic                branch_taken = 1'b0;
  logic [PC_WIDTH-1:0] branch_target = '0;
  logic                instr_ready = 1'b0;
  logic                instr_valid;
  logic [2:0]          opcode;
  logic [3:0]          Funccode;
  logic [4:0]          rs;
  logic [4:0]          rt;
  logic [15:0]         imm16;
  logic [PC_WIDTH-1:0] pc_out;
  logic                halted;
  logic                illegal_instr;

  logic [31:0] mem [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  wire [78:0] all_outs = {instr_valid, imem_en, halted, illegal_instr, opcode, Funccode,
                          rs, rt, imm16, pc_out, imem_addr};
  wire [32:0] obs_fields = {opcode, Funccode, rs, rt, imm16};

  instr_fetch_unit #(.PC_WIDTH(PC_WIDTH), .RESET_PC(32'h0), .IMEM_AW(IMEM_AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_ready   (instr_ready),
    .instr_valid   (instr_valid),
    .opcode        (opcode),
    .Funccode      (Funccode),
    .rs            (rs),
    .rt            (rt),
    .imm16         (imm16),
    .pc_out        (pc_out),
    .halted        (halted),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  // Synchronous BRAM, one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  function automatic logic [32:0] exp_fields(input logic [31:0] w);
    return {w[31:29], w[3:0], w[28:24], w[23:19], w[15:0]};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < int'(DEPTH); i++)
      mem[i] = {3'($urandom_range(0, 5)), 29'($urandom)};
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    branch_taken = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (instr_valid) begin ok = 1'b1; break; end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s: instr_valid never rose within 40 cycles", tag); end
  endtask

  task automatic wait_fetch(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_en) begin ok = 1'b1; break; end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s: imem_en never rose within 40 cycles", tag); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
  endtask

  task automatic test_sequential();
    bit         ok;
    int         last_cyc;
    logic [2:0] e_opc;
    logic [3:0] e_fn;
    logic [31:0] e_pc;
    fill_mem();
    mem[0] = 32'h0000_0001;
    mem[1] = 32'h2000_0003;
    mem[2] = 32'h4000_0000;
    instr_ready = 1'b1;
    apply_reset();
    last_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      wait_valid("seq_valid", ok);
      if (!ok) return;
      e_opc = (k == 0) ? 3'b000 : (k == 1) ? 3'b001 : 3'b010;
      e_fn  = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0011 : 4'b0000;
      e_pc  = 32'(4 * k);
      checks++;
      if (opcode !== e_opc || Funccode !== e_fn || pc_out !== e_pc) begin
        errors++;
        $display("FAIL seq_issue%0d: opcode=%b func=%b pc=%h expected %b %b %h",
                 k, opcode, Funccode, pc_out, e_opc, e_fn, e_pc);
      end
      if (k > 0) begin
        checks++;
        if (cyc - last_cyc != 3) begin
          errors++; $display("FAIL seq_spacing%0d: got %0d cycles expected 3", k, cyc - last_cyc);
        end
      end
      last_cyc = cyc;
      tick();
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_stall();
    bit          ok;
    logic [31:0] s_pc;
    logic [32:0] s_f;
    fill_mem();
    instr_ready = 1'b0;
    apply_reset();
    wait_valid("stall_valid", ok);
    if (!ok) return;
    s_pc = pc_out;
    s_f  = obs_fields;
    checks++;
    if (s_pc !== 32'h0 || s_f !== exp_fields(mem[0])) begin
      errors++; $display("FAIL stall_first: pc=%h fields=%h expected 0 %h", s_pc, s_f, exp_fields(mem[0]));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== s_pc || obs_fields !== s_f || imem_en !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b pc=%h fields=%h en=%b expected 1 %h %h 0",
                 i, instr_valid, pc_out, obs_fields, imem_en, s_pc, s_f);
      end
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    s_pc = s_pc + 32'd4;
    checks++;
    if (instr_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== s_pc[11:2]) begin
      errors++;
      $display("FAIL stall_release: valid=%b en=%b addr=%0d expected 0 1 %0d",
               instr_valid, imem_en, imem_addr, s_pc[11:2]);
    end
  endtask

  task automatic test_branch_resp();
    bit ok;
    fill_mem();
    instr_ready = 1'b1;
    apply_reset();
    wait_fetch("brresp_fetch", ok);
    if (!ok) return;
    tick();
    branch_taken = 1'b1;
    branch_target = 32'h40;
    tick();
    branch_taken = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 10'd16) begin
      errors++;
      $display("FAIL brresp_redirect: valid=%b en=%b addr=%0d expected 0 1 16", instr_valid, imem_en, imem_addr);
    end
    wait_valid("brresp_valid", ok);
    if (!ok) return;
    checks++;
    if (pc_out !== 32'h40 || obs_fields !== exp_fields(mem[16])) begin
      errors++;
      $display("FAIL brresp_target: pc=%h fields=%h expected 40 %h", pc_out, obs_fields, exp_fields(mem[16]));
    end
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_branch_xfer();
    bit ok;
    fill_mem();
    instr_ready = 1'b1;
    apply_reset();
    wait_valid("brx_valid", ok);
    if (!ok) return;
    branch_taken = 1'b1;
    branch_target = 32'h43;
    tick();
    branch_taken = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 10'd16) begin
      errors++;
      $display("FAIL brx_redirect: valid=%b en=%b addr=%0d expected 0 1 16", instr_valid, imem_en, imem_addr);
    end
    wait_valid("brx_next", ok);
    if (!ok) return;
    checks++;
    if (pc_out !== 32'h40) begin
      errors++; $display("FAIL brx_pc: got %h expected 40", pc_out);
    end
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_halt();
    bit ok;
    fill_mem();
    mem[0] = 32'hE000_000F;
    instr_ready = 1'b1;
    apply_reset();
    wait_valid("halt_valid", ok);
    if (!ok) return;
    checks++;
    if (opcode !== 3'b111 || Funccode !== 4'b1111) begin
      errors++; $display("FAIL halt_fields: opcode=%b func=%b expected 111 1111", opcode, Funccode);
    end
    tick();
    checks++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_en !== 1'b0) begin
      errors++;
      $display("FAIL halt_enter: halted=%b valid=%b en=%b expected 1 0 0", halted, instr_valid, imem_en);
    end
    for (int i = 0; i < 20; i++) begin
      branch_taken = 1'($urandom_range(0, 1));
      branch_target = $urandom;
      tick();
      checks++;
      if (imem_en !== 1'b0 || halted !== 1'b1 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold%0d: en=%b halted=%b valid=%b expected 0 1 0", i, imem_en, halted, instr_valid);
      end
    end
    branch_taken = 1'b0;
    apply_reset();
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL halt_reset: got %h expected 0", all_outs);
    end
    wait_fetch("halt_restart", ok);
    if (!ok) return;
    checks++;
    if (imem_addr !== 10'd0) begin
      errors++; $display("FAIL halt_restart_addr: got %0d expected 0", imem_addr);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_illegal();
    bit ok;
    fill_mem();
    mem[0] = 32'hC000_0000;
    instr_ready = 1'b1;
    apply_reset();
    wait_valid("ill_valid", ok);
    if (!ok) return;
    checks++;
    if (opcode !== 3'b110 || illegal_instr !== 1'b1) begin
      errors++; $display("FAIL ill_issue: opcode=%b illegal=%b expected 110 1", opcode, illegal_instr);
    end
    tick();
    wait_valid("ill_next", ok);
    if (!ok) return;
    checks++;
    if (illegal_instr !== 1'b1 || pc_out !== 32'h4) begin
      errors++; $display("FAIL ill_sticky: illegal=%b pc=%h expected 1 4", illegal_instr, pc_out);
    end
    tick();
    wait_fetch("ill_fetch", ok);
    if (!ok) return;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL ill_reset_resp: got %h expected 0", all_outs);
    end
    reset = 1'b0;
    instr_ready = 1'b0;
  endtask

  // Program-order model: every accepted instruction comes from the model PC,
  // which advances by 4 per acceptance and jumps on a redirect.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic [31:0] w;
    bit          br;
    int          transfers;
    fill_mem();
    instr_ready = 1'b0;
    apply_reset();
    exp_pc = 32'h0;
    transfers = 0;
    for (int c = 0; c < 900; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      br = ($urandom_range(0, 9) == 0);
      tgt = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 4095));
      branch_taken = br;
      branch_target = tgt;
      if (instr_valid && instr_ready) begin
        w = mem[exp_pc[11:2]];
        checks++;
        if (pc_out !== exp_pc || obs_fields !== exp_fields(w) || illegal_instr !== 1'b0) begin
          errors++;
          $display("FAIL rand_xfer%0d: pc=%h fields=%h ill=%b expected %h %h 0",
                   transfers, pc_out, obs_fields, illegal_instr, exp_pc, exp_fields(w));
        end
        exp_pc = exp_pc + 32'd4;
        transfers++;
      end
      if (br) exp_pc = {tgt[31:2], 2'b00};
      tick();
    end
    branch_taken = 1'b0;
    instr_ready = 1'b0;
    checks++;
    if (transfers < 50) begin
      errors++; $display("FAIL rand_progress: got %0d transfers expected at least 50", transfers);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_resp();
    test_branch_xfer();
    test_halt();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
